// File: rtl/priority_encoder_n.sv
// Registered N-to-W priority encoder with a one-stage valid/ready output register.
// Fixed priority (lowest index wins) or round-robin grant, plus empty and multi-hot flags.
module priority_encoder_n #(
  parameter int unsigned N       = 32,
  parameter int unsigned W       = 5,
  parameter int unsigned RR_MODE = 0
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] code,
  output logic         none,
  output logic         multi
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] code_q, code_d;
  logic         none_q, none_d;
  logic         multi_q, multi_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic [N-1:0] mask_hi;
  logic [N-1:0] masked;
  logic [W-1:0] grant;
  logic [W-1:0] ptr_next;
  logic         none_c;
  logic         multi_c;

  function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Round-robin searches [ptr, N-1] first and falls back to the whole vector, which is
  // the same grant as a search over the doubled vector starting at ptr.
  always_comb begin
    mask_hi = '0;
    for (int i = 0; i < int'(N); i++) begin
      mask_hi[i] = (RR_MODE != 0) && (i >= int'(ptr_q));
    end
  end

  assign masked  = data & mask_hi;
  assign grant   = (|masked) ? lowest_set(masked) : lowest_set(data);
  assign none_c  = ~|data;
  assign multi_c = |(data & (data - {{(N-1){1'b0}}, 1'b1}));

  // Wrap at N, not 2^W, so non-power-of-two widths never point past the last request.
  assign ptr_next = (grant == W'(N - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    out_valid_d = out_valid_q;
    code_d      = code_q;
    none_d      = none_q;
    multi_d     = multi_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      code_d      = grant;
      none_d      = none_c;
      multi_d     = multi_c;
      if ((RR_MODE != 0) && !none_c) ptr_d = ptr_next;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      out_valid_q <= 1'b0;
      code_q      <= '0;
      none_q      <= 1'b0;
      multi_q     <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
      none_q      <= none_d;
      multi_q     <= multi_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign code      = code_q;
  assign none      = none_q;
  assign multi     = multi_q;

endmodule

// File: tb/tb_priority_encoder_n.sv
// Bench for priority_encoder_n: fixed N=32, round-robin N=32 and round-robin N=5 instances,
// checked against a reference encoder and an expected-output queue per instance.
module tb_priority_encoder_n;

  logic        clock;
  logic        clear;
  logic [2:0]  in_valid, out_ready, in_ready, out_valid, none, multi;
  logic [31:0] dvec [3];
  logic [31:0] data_a, data_b;
  logic [4:0]  data_c;
  logic [4:0]  code_a, code_b;
  logic [2:0]  code_c;

  assign data_a = dvec[0];
  assign data_b = dvec[1];
  assign data_c = dvec[2][4:0];

  priority_encoder_n #(.N(32), .W(5), .RR_MODE(0)) u_fixed (
    .clock(clock), .clear(clear), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data(data_a), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .code(code_a),
    .none(none[0]), .multi(multi[0])
  );

  priority_encoder_n #(.N(32), .W(5), .RR_MODE(1)) u_rr (
    .clock(clock), .clear(clear), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data(data_b), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .code(code_b),
    .none(none[1]), .multi(multi[1])
  );

  priority_encoder_n #(.N(5), .W(3), .RR_MODE(1)) u_rr5 (
    .clock(clock), .clear(clear), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data(data_c), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .code(code_c),
    .none(none[2]), .multi(multi[2])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int code;
    bit none;
    bit multi;
  } exp_t;

  exp_t sb [3][$];
  exp_t last [3];
  int   mptr [3];
  int   checks;
  int   failures;

  function automatic int width_of(input int i);
    return (i == 2) ? 5 : 32;
  endfunction

  function automatic logic [31:0] code_of(input int i);
    case (i)
      0:       return {27'b0, code_a};
      1:       return {27'b0, code_b};
      default: return {29'b0, code_c};
    endcase
  endfunction

  // Reference grant: walk n positions starting at ptr (rr) or at 0 (fixed).
  function automatic exp_t enc(input logic [31:0] d, input int n, input bit rr, input int ptr);
    exp_t e;
    int   cnt;
    bit   found;
    cnt    = 0;
    found  = 0;
    e.code = 0;
    for (int k = 0; k < n; k++) if (d[k]) cnt++;
    e.none  = (cnt == 0);
    e.multi = (cnt >= 2);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = rr ? (ptr + k) % n : k;
      if (!found && d[idx]) begin
        e.code = idx;
        found  = 1;
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      if (sb[i].size() > 0) begin
        e = sb[i][0];
        chk($sformatf("u%0d.out_valid", i), {31'b0, out_valid[i]}, 32'd1);
      end else begin
        e = last[i];
        chk($sformatf("u%0d.out_valid", i), {31'b0, out_valid[i]}, 32'd0);
      end
      chk($sformatf("u%0d.code", i), code_of(i), e.code);
      chk($sformatf("u%0d.none", i), {31'b0, none[i]}, {31'b0, e.none});
      chk($sformatf("u%0d.multi", i), {31'b0, multi[i]}, {31'b0, e.multi});
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int          n;
      bit          busy, rdy, acc;
      logic [31:0] d;
      exp_t        e;
      n    = width_of(i);
      busy = (sb[i].size() > 0);
      rdy  = !busy || out_ready[i];
      acc  = in_valid[i] && rdy;
      if (busy && out_ready[i]) void'(sb[i].pop_front());
      if (acc) begin
        d = (n == 32) ? dvec[i] : (dvec[i] & ((32'd1 << n) - 32'd1));
        e = enc(d, n, i != 0, mptr[i]);
        sb[i].push_back(e);
        last[i] = e;
        if (i != 0 && !e.none) mptr[i] = (e.code + 1) % n;
      end
    end
  endtask

  task automatic tick();
    #2;
    for (int i = 0; i < 3; i++) begin
      logic exp_rdy;
      exp_rdy = clear ? 1'b1 : ((sb[i].size() == 0) || out_ready[i]);
      chk($sformatf("u%0d.in_ready", i), {31'b0, in_ready[i]}, {31'b0, exp_rdy});
    end
    if (!clear) model_edge();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      dvec[i]      = $urandom;
    end
  endtask

  task automatic step(input int i, input bit v, input logic [31:0] d, input bit rdy);
    idle_all();
    in_valid[i]  = v;
    dvec[i]      = d;
    out_ready[i] = rdy;
    tick();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      sb[i].delete();
      last[i] = '{0, 1'b0, 1'b0};
      mptr[i] = 0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear    = 1'b1;
    model_clear();
    idle_all();

    // Reset state, and data offered during clear must not be taken.
    #2;
    check_outputs();
    in_valid[0] = 1'b1;
    dvec[0]     = 32'h0000_0005;
    tick();
    tick();
    clear = 1'b0;

    for (int k = 0; k < 32; k++) step(0, 1'b1, 32'h1 << k, 1'b1);
    idle_all();
    tick();

    step(0, 1'b1, 32'h8000_0011, 1'b1);
    idle_all();
    tick();

    // Round-robin: expect 0, 4, 31, 0, then empty, then 4.
    repeat (4) step(1, 1'b1, 32'h8000_0011, 1'b1);
    step(1, 1'b1, 32'h0000_0000, 1'b1);
    step(1, 1'b1, 32'h8000_0011, 1'b1);
    idle_all();
    tick();

    // Backpressure with a pending vector, then release.
    step(1, 1'b1, 32'h0000_0300, 1'b1);
    repeat (5) step(1, 1'b1, 32'h0000_0101, 1'b0);
    step(1, 1'b1, 32'h0000_0101, 1'b1);
    idle_all();
    tick();

    repeat (4) step(2, 1'b1, 32'h0000_0011, 1'b1);
    for (int k = 0; k < 5; k++) step(2, 1'b1, 32'h1 << k, 1'b1);
    idle_all();
    tick();

    for (int r = 0; r < 90; r++) begin
      int u;
      u = $urandom_range(0, 2);
      step(u, $urandom_range(0, 3) != 0, $urandom & $urandom, $urandom_range(0, 2) != 0);
    end
    idle_all();
    tick();

    // Async clear between edges with output pending and ptr at 5.
    step(1, 1'b1, 32'h0000_0010, 1'b1);
    #2;
    clear = 1'b1;
    #1;
    model_clear();
    check_outputs();
    idle_all();
    in_valid[1] = 1'b1;
    dvec[1]     = 32'h8000_0011;
    tick();
    #3;
    clear = 1'b0;
    step(1, 1'b1, 32'h8000_0011, 1'b1);
    idle_all();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_encoder_n.md
# priority_encoder_n

Parametrised, registered N-to-log2(N) encoder. Successor to the fixed 32:5 one-hot encoder that drives bus-source and register selects. Adds:

- a configurable input width;
- fixed-priority or round-robin arbitration when several request bits are set;
- flags for empty and multi-hot inputs;
- a one-stage valid/ready pipeline register, so it can sit between the control unit's select generation and the bus multiplexer.

## Interface
- N, default 32: number of request lines; legal range 2..64.
- W, default 5: code width; must equal ceil(log2(N)).
- RR_MODE, default 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- clock  input  1  rising-edge clock.
- clear  input  1  asynchronous active-high reset.
- in_valid  input  1  data is presented this cycle.
- in_ready  output  1  block accepts data this cycle.
- data  input  N  request/select vector.
- out_valid  output  1  code and flags are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- code  output  W  index of the granted bit.
- none  output  1  the accepted vector was all zero.
- multi  output  1  the accepted vector had two or more bits set.

## Operation
- **Accept rule:** accept occurs when in_valid && in_ready.
- **Ready rule:** in_ready = !out_valid || out_ready. This is combinational and allows back-to-back accepts at full throughput.
- **On accept, register the following:**
  - code = granted index;
  - none = (data == 0);
  - multi = (popcount(data) >= 2);
  - out_valid = 1.
- **Holding:** if there is no accept and out_ready=1, out_valid goes to 0. code, none and multi keep their last values.
- **Fixed mode (RR_MODE=0):** grant the lowest set index. Pointer is unused.
- **Round-robin mode (RR_MODE=1):**
  - Internal pointer ptr, range 0..N-1.
  - Grant the first set bit searching upward from ptr, wrapping N-1 to 0.
  - After an accept with none=0, ptr = (granted index + 1) mod N.
  - Wrap uses N itself, not 2^W; N need not be a power of two.
- **Zero input:** code = 0, none = 1, multi = 0. ptr is unchanged.
- **Single-hot input:** code equals the bit position in both modes, with multi = 0. For N=32 this matches the legacy encoder for every legal one-hot input.
- **Clear:** asynchronous and active-high, takes effect immediately regardless of clock.
  - Reset values: out_valid 0, code 0, none 0, multi 0, ptr 0.
  - Any pending output is discarded. It is not replayed after clear deasserts.
  - in_ready is 1 while clear is asserted, but data presented during clear is not accepted.
- **Data outside accept:** data is ignored when in_valid=0. X on data is tolerated when in_valid=0.

## Timing
- **Latency:** 1 cycle. Data accepted at edge k appears on code, none and multi with out_valid=1 after edge k.
- **Throughput:** 1 vector per cycle when out_ready is held high.
- **Backpressure** (out_valid=1, out_ready=0):
  - in_ready = 0.
  - code, none, multi and ptr are held stable until the handshake completes.
- **Simultaneous events:** when out_ready=1 and a new accept occur in the same cycle, the output register is overwritten and out_valid stays 1.
- **Round-robin update:** ptr updates on the same edge that registers the grant. A vector accepted on the following cycle sees the new ptr.
- **Critical path:** masked priority search over 2N bits, for the doubled vector in round-robin mode. It must close at the CPU clock for N ≤ 32.

## Test plan
- **Fixed mode, N=32, one-hot sweep:** data = 1<<i for i = 0..31, one per cycle, out_ready=1.
  - Required: code = i one cycle later, none=0, multi=0, out_valid continuous.
- **Fixed mode, multi-hot:** data = 32'h8000_0011.
  - Required: code=0, multi=1, none=0.
- **Round-robin mode, N=32:** data = 32'h8000_0011 held valid for 4 accepts.
  - Required: codes 0, 4, 31, 0, all with multi=1.
  - Then data = 0: none=1, code=0, and the next 32'h8000_0011 grants 4.
- **Backpressure:** out_ready=0 after the first accept, in_valid held with new data.
  - Required: in_ready=0, and code, flags and ptr are frozen for 5 cycles.
  - Then out_ready=1: the held output is consumed and the pending data is accepted in the same cycle.
- **Non-power-of-two, N=5 with W=3, round-robin:** data = 5'b10001 repeated.
  - Required: codes 0, 4, 0, 4, confirming ptr wraps from 4 to 0 and never visits 5..7.
- **Async clear mid-operation:** assert clear between edges while out_valid=1, with round-robin ptr non-zero.
  - Required: out_valid, code and flags go to 0 immediately, with no clock edge needed.
  - After release, the first accept of 32'h8000_0011 grants code 0 (ptr reset to 0).
